// File: rtl/envelope_scheduler_if.sv
// envelope_scheduler_if
// Bundles the voice-control, ROM and envelope output signals of
// envelope_scheduler.
//   note_on/note_off : per-voice one-cycle pulses from the note decoder
//   rom_addr         : envelope ROM index (scheduler -> ROM)
//   rom_data         : envelope ROM registered output (ROM -> scheduler)
//   env_out          : per-voice 10-bit amplitude, voice 0 in bits [9:0]
//   env_valid        : per-voice pulse when the env_out slice was refreshed
//   voice_active     : per-voice "currently sounding" flag
// slave  = scheduler side, master = decoder/ROM/multiplier side.
`timescale 1ns/1ps
interface envelope_scheduler_if #(
  parameter int NUM_VOICES = 4
);
  logic [NUM_VOICES-1:0]    note_on;
  logic [NUM_VOICES-1:0]    note_off;
  logic [5:0]               rom_addr;
  logic [9:0]               rom_data;
  logic [10*NUM_VOICES-1:0] env_out;
  logic [NUM_VOICES-1:0]    env_valid;
  logic [NUM_VOICES-1:0]    voice_active;

  modport master (
    output note_on, note_off, rom_data,
    input  rom_addr, env_out, env_valid, voice_active
  );

  modport slave (
    input  note_on, note_off, rom_data,
    output rom_addr, env_out, env_valid, voice_active
  );
endinterface

// File: rtl/envelope_scheduler.sv
// envelope_scheduler
// Shares one single-port envelope ROM (6-bit index, 10-bit amplitude,
// one-cycle registered read) between NUM_VOICES voices. Each voice keeps an
// active flag, a ROM index and an amplitude register. All active indices
// advance on a prescaled tempo tick; ROM lookups are issued round-robin, one
// voice per cycle, and the returned amplitude is written back one cycle later.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : envelope_scheduler_if.slave (note_on/note_off in, rom_addr out,
//           rom_data in, env_out/env_valid/voice_active out)
`timescale 1ns/1ps
module envelope_scheduler #(
  parameter int NUM_VOICES = 4,
  parameter int TICK_DIV   = 1024,
  parameter int LAST_INDEX = 63
) (
  input  logic                 clk,
  input  logic                 reset,
  envelope_scheduler_if.slave  bus
);

  localparam int PTR_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_VOICES - 1);
  localparam logic [5:0]       IDX_LAST = 6'(LAST_INDEX);

  // The index never wraps: reaching the last entry expires the voice instead.
  function automatic logic at_last(input logic [5:0] idx);
    return idx == IDX_LAST;
  endfunction

  function automatic logic [5:0] step_index(input logic [5:0] idx);
    return idx + 6'd1;
  endfunction

  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            tick;
  logic [PTR_W-1:0]                ptr_q, ptr_d;
  logic [NUM_VOICES-1:0]           active_q, active_d;
  logic [NUM_VOICES-1:0][5:0]      idx_q, idx_d;
  logic [NUM_VOICES-1:0][9:0]      env_q, env_d;
  logic [NUM_VOICES-1:0]           envv_q, envv_d;

  // Issue/capture stage: which voice and index the ROM is currently answering.
  logic [PTR_W-1:0]                ptr_p1_q;
  logic [5:0]                      idx_p1_q;
  logic                            vld_p1_q, vld_p1_d;

  logic [NUM_VOICES-1:0]           kill;
  logic                            cap_ok;

  assign tick  = (cnt_q == CNT_LAST);
  assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  assign ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);

  // A note_on in the issue cycle restarts the voice even if its index was
  // already 0, so the index comparison alone cannot catch it.
  assign vld_p1_d = active_q[ptr_q] & ~bus.note_on[ptr_q];

  // Events on the capture edge that would restart, silence or expire the
  // voice override the returned amplitude.
  always_comb begin
    kill = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      kill[v] = bus.note_on[v] | bus.note_off[v] |
                (tick & active_q[v] & at_last(idx_q[v]));
    end
  end

  // The returned word is only trusted if the voice still sits on the index
  // that was issued (a tick or note event in between changes or clears it).
  assign cap_ok = vld_p1_q && active_q[ptr_p1_q] &&
                  (idx_q[ptr_p1_q] == idx_p1_q) && !kill[ptr_p1_q];

  always_comb begin
    active_d = active_q;
    idx_d    = idx_q;
    env_d    = env_q;
    envv_d   = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (cap_ok && (ptr_p1_q == PTR_W'(v))) begin
        env_d[v]  = bus.rom_data;
        envv_d[v] = 1'b1;
      end
      // note_on keeps env[v]: the old amplitude is held until the first
      // fresh capture for the restarted envelope.
      if (bus.note_on[v]) begin
        active_d[v] = 1'b1;
        idx_d[v]    = '0;
      end else if (bus.note_off[v]) begin
        active_d[v] = 1'b0;
        idx_d[v]    = '0;
        env_d[v]    = '0;
      end else if (tick && active_q[v]) begin
        if (at_last(idx_q[v])) begin
          active_d[v] = 1'b0;
          idx_d[v]    = '0;
          env_d[v]    = '0;
        end else begin
          idx_d[v] = step_index(idx_q[v]);
        end
      end
    end
  end

  // Stage p0: voice state, prescaler, slot pointer, capture valid
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      ptr_q    <= '0;
      active_q <= '0;
      idx_q    <= '0;
      env_q    <= '0;
      envv_q   <= '0;
      vld_p1_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      active_q <= active_d;
      idx_q    <= idx_d;
      env_q    <= env_d;
      envv_q   <= envv_d;
      vld_p1_q <= vld_p1_d;
    end
  end

  // Stage p1: issued slot and index, qualified by vld_p1_q
  always_ff @(posedge clk) begin
    ptr_p1_q <= ptr_q;
    idx_p1_q <= idx_q[ptr_q];
  end

  assign bus.rom_addr     = active_q[ptr_q] ? idx_q[ptr_q] : '0;
  assign bus.env_out      = env_q;
  assign bus.env_valid    = envv_q;
  assign bus.voice_active = active_q;

endmodule

// File: doc/envelope_scheduler.md
# envelope_scheduler

Time-multiplexes the single-port exponential envelope ROM (6-bit index in, 10-bit amplitude out, one-cycle registered read) across NUM_VOICES synthesizer voices. Keeps a per-voice envelope index, advances all active indices on a shared prescaled tempo tick, and round-robins ROM lookups. It writes each returned amplitude into a per-voice envelope register. Sits between the note/keyboard decoder and the per-voice amplitude multipliers.

## Interface
- NUM_VOICES, 4, voice count; 2..8
- TICK_DIV, 1024, clk cycles per envelope step; must be >= NUM_VOICES
- LAST_INDEX, 63, final ROM index before a voice expires; <= 63
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- note_on  in  NUM_VOICES  per-voice one-cycle pulse; (re)starts envelope at index 0
- note_off  in  NUM_VOICES  per-voice one-cycle pulse; kills voice immediately
- rom_addr  out  6  to ROM duration input; combinational from slot pointer and index
- rom_data  in  10  ROM dout, valid the cycle after rom_addr is presented
- env_out  out  10*NUM_VOICES  per-voice amplitude, voice 0 in bits [9:0]
- env_valid  out  NUM_VOICES  one-cycle pulse when env_out slice updated
- voice_active  out  NUM_VOICES  voice currently sounding

## Operation
- Prescaler: counter 0..TICK_DIV-1, wraps; tick asserted the cycle it equals TICK_DIV-1.
- Per voice: active flag, 6-bit index, stale flag, 10-bit env register.
- Priority per voice per cycle: note_on > note_off > tick.
- note_on: index <= 0, active <= 1, stale <= 1 (env_out retains old value until first fresh capture).
- note_off: active <= 0, index <= 0, env <= 0.
- tick, active voice: index < LAST_INDEX -> index+1; index == LAST_INDEX -> active <= 0, env <= 0, index <= 0.
- Slot pointer ptr cycles 0..NUM_VOICES-1, one step per clk, wraps. rom_addr = index[ptr] when active[ptr], else 0.
- Capture stage: ptr_d/issued-index registered each cycle. Next cycle, capture rom_data into env[ptr_d] with env_valid[ptr_d]=1 only if voice still active, not note_on/note_off/tick-modified for that voice since issue (index unchanged, no retrigger); otherwise discard, no pulse. Capture clears stale.
- Inactive voices: env_out slice 0, env_valid never pulses.
- Index arithmetic unsigned 6-bit, never wraps (saturation handled by expiry).

## Timing
- Reset values: env_out all 0, env_valid 0, voice_active 0, all indices 0, ptr 0, prescaler 0, capture stage invalid; rom_addr therefore 0.
- Reset mid-operation: everything above cleared at the next edge; in-flight capture discarded.
- Lookup latency: address presented cycle t; ROM registers at edge ending t; env_out/env_valid update at edge ending t+1.
- Refresh period per voice: NUM_VOICES cycles; worst-case note_on to first env_valid: NUM_VOICES+2 cycles.
- Envelope step for voice: ROM[index] sequence 384,512,640,768,896,1023, then decaying to ROM[LAST_INDEX].
- Voice lifetime after note_on: (LAST_INDEX+1) ticks, subject to the first partial prescaler period.

## Test plan
- Reset: hold reset 3 cycles mid-run with 2 voices active -> next cycle all env_out 0, voice_active 0, env_valid 0, rom_addr 0.
- Single voice, NUM_VOICES=4, TICK_DIV=16: note_on[0] -> env_valid[0] within 6 cycles with env_out[0]=384, then successive ticks give 512,640,768,896,1023,1001,981.
- Expiry: LAST_INDEX=63, let voice 0 run -> last captured value 305, next tick voice_active[0]=0, env_out[0]=0, no further env_valid[0].
- Round-robin: note_on to all 4 voices staggered by 3 ticks -> each env_valid bit pulses exactly every 4 cycles; voice k env matches ROM[its own index], no crosstalk.
- Retrigger/conflict: note_on[1] at index 40 (value 493) -> next capture 384; same-cycle note_on[2]+note_off[2] -> voice 2 active, index 0; note_on coinciding with tick -> index 0, not 1.
- Stale discard: note_off[3] the cycle after voice 3 was issued -> no env_valid[3], env_out[3] stays 0.
